// File: rtl/signed_div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Iteration count depends on SIGNED_DIV_RADIX4_EN at the top level.
package signed_div_pkg;

  localparam int N  = 8;
  localparam int DW = 2 * N;
  localparam int RW = N + 1;
  localparam int CW = 5;

  localparam logic [N-1:0] Q_POS_SAT = 8'h7F;
  localparam logic [N-1:0] Q_NEG_SAT = 8'h80;

  localparam logic [CW-1:0] ITER_R2 = 5'd16;
  localparam logic [CW-1:0] ITER_R4 = 5'd8;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX
  } state_t;

endpackage

// File: rtl/signed_div_step.sv
// One restoring division step on magnitudes.
// Partial remainder stays below |divisor| so 9 bits hold it.
module signed_div_step
  import signed_div_pkg::*;
(
  input  logic [RW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [N-1:0]  dvs,
  output logic [RW-1:0] rem_out,
  output logic          q_bit
);

  logic [RW:0] trial;

  // shift in the next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    trial   = {rem_in, bit_in} - {2'b00, dvs};
    q_bit   = ~trial[RW];
    rem_out = q_bit ? trial[RW-1:0]
                    : {rem_in[RW-2:0], bit_in};
  end

endmodule

// File: rtl/signed_div16x8_seq.sv
// 16/8 signed sequential divider, restoring on magnitudes.
// Define SIGNED_DIV_RADIX4_EN for two quotient bits per cycle.
module signed_div16x8_seq
  import signed_div_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [15:0]  dividend,
  input  logic [7:0]   divisor,
  output logic         busy,
  output logic         done,
  output logic [7:0]   quotient,
  output logic [7:0]   remainder,
  output logic         overflow,
  output logic         div_by_zero
);

`ifdef SIGNED_DIV_RADIX4_EN
  localparam logic [CW-1:0] ITER = ITER_R4;
`else
  localparam logic [CW-1:0] ITER = ITER_R2;
`endif

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  count;
  logic [DW-1:0]  shreg;
  logic [DW-1:0]  shreg_nxt;
  logic [RW-1:0]  rem;
  logic [RW-1:0]  rem_nxt;
  logic [N-1:0]   dvs_mag;
  logic           sign_q;
  logic           sign_r;
  logic           dz;
  logic           in_range;
  logic [N-1:0]   q_fix;
  logic [N-1:0]   r_fix;

  // shreg starts as |dividend| and fills with quotient bits from the LSB
`ifdef SIGNED_DIV_RADIX4_EN
  logic [RW-1:0] rem_mid;
  logic          q_hi;
  logic          q_lo;

  signed_div_step u_step_hi (
    .rem_in  (rem),
    .bit_in  (shreg[DW-1]),
    .dvs     (dvs_mag),
    .rem_out (rem_mid),
    .q_bit   (q_hi)
  );

  signed_div_step u_step_lo (
    .rem_in  (rem_mid),
    .bit_in  (shreg[DW-2]),
    .dvs     (dvs_mag),
    .rem_out (rem_nxt),
    .q_bit   (q_lo)
  );

  assign shreg_nxt = {shreg[DW-3:0], q_hi, q_lo};
`else
  logic q_bit;

  signed_div_step u_step (
    .rem_in  (rem),
    .bit_in  (shreg[DW-1]),
    .dvs     (dvs_mag),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign shreg_nxt = {shreg[DW-2:0], q_bit};
`endif

  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic: IDLE -> DIV -> FIX -> IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DIV;
      DIV:     if (count == ITER - 1'b1)
                 state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // range check and sign fix-up of the magnitude results
  always_comb begin
    in_range = (shreg[DW-1:N] == '0) &&
               (!shreg[N-1] ||
                (sign_q && shreg[N-2:0] == '0));
    q_fix    = sign_q ? -shreg[N-1:0] : shreg[N-1:0];
    r_fix    = sign_r ? -rem[N-1:0] : rem[N-1:0];
  end

  // operand capture, iteration and result write-back
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count       <= '0;
      shreg       <= '0;
      rem         <= '0;
      dvs_mag     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg   <= dividend[15] ? -dividend
                                    : dividend;
            dvs_mag <= divisor[7] ? -divisor
                                  : divisor;
            sign_q  <= dividend[15] ^ divisor[7];
            sign_r  <= dividend[15];
            dz      <= (divisor == '0);
            rem     <= '0;
            count   <= '0;
          end
        end
        DIV: begin
          rem   <= rem_nxt;
          shreg <= shreg_nxt;
          count <= count + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (dz) begin
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
          end else if (in_range) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end else begin
            quotient    <= sign_q ? Q_NEG_SAT
                                  : Q_POS_SAT;
            remainder   <= '0;
            overflow    <= 1'b1;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div16x8_seq.sv
// Bench for signed_div16x8_seq: vector table, random ops
// against an integer model, handshake and reset sequences.
module tb_signed_div16x8_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        overflow;
  logic        div_by_zero;

  int total = 0;
  int bad = 0;
  int both_hi = 0;

`ifdef SIGNED_DIV_RADIX4_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ov;
    logic        dz;
  } vec_t;

  vec_t tbl [10];

  signed_div16x8_seq dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (done && busy) both_hi++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // {q, r, ov, dz} from plain integer division
  function automatic logic [17:0] model(
    input logic [15:0] a,
    input logic [7:0]  b);
    int sa, sb, q, r;
    if (b == 8'h00) return {8'h00, 8'h00, 2'b01};
    sa = int'($signed(a));
    sb = int'($signed(b));
    q = sa / sb;
    r = sa % sb;
    if (q > 127 || q < -128)
      return {(q < 0) ? 8'h80 : 8'h7F, 8'h00, 2'b10};
    return {q[7:0], r[7:0], 2'b00};
  endfunction

  task automatic do_op(input logic [15:0] a,
                       input logic [7:0] b,
                       output int lat);
    @(negedge CLK);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge CLK);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge CLK);
      #1 lat++;
    end
  endtask

  task automatic chk_res(input string name,
                         input int lat,
                         input int exp_lat,
                         input logic [17:0] e);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_q"}, quotient, e[17:10]);
    chk({name, "_r"}, remainder, e[9:2]);
    chk({name, "_flags"},
        {overflow, div_by_zero}, e[1:0]);
  endtask

  initial begin
    int lat;
    int lat2;
    int n_done;
    logic [15:0] ra;
    logic [7:0]  rb;

    RST = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs",
        {busy, done, overflow, div_by_zero,
         quotient, remainder}, 0);
    @(negedge CLK) RST = 1'b0;

    tbl[0] = '{16'hEE56, 8'h26, 8'h89, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
    tbl[2] = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
    tbl[3] = '{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{16'h0080, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 8'hFF, 8'h7F, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{16'h8000, 8'h80, 8'h7F, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{16'h1234, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[9] = '{16'h0064, 8'h05, 8'h14, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].a, tbl[i].b, lat);
      chk_res($sformatf("vec%0d", i), lat, LAT,
              {tbl[i].q, tbl[i].r, tbl[i].ov, tbl[i].dz});
    end

    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      if (i % 4 == 1) ra = 16'($signed(ra[11:0]));
      if (i % 16 == 0) rb = 8'h00;
      do_op(ra, rb, lat);
      chk_res($sformatf("rnd%0d", i), lat, LAT,
              model(ra, rb));
    end

    // start while busy must be ignored
    @(negedge CLK);
    start = 1'b1;
    dividend = 16'h0064;
    divisor = 8'hF9;
    @(posedge CLK);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 2) begin
        start = 1'b1;
        dividend = 16'h7FFF;
        divisor = 8'h03;
      end
      @(posedge CLK);
      #1 lat++;
      start = 1'b0;
    end
    chk_res("ignore", lat, LAT,
            {8'hF2, 8'h02, 2'b00});
    @(posedge CLK);
    #1 chk("ignore_no_queue", busy, 1'b0);

    // start in the done cycle: accepted on the next edge
    do_op(16'hEE56, 8'h26, lat);
    chk_res("b2b_first", lat, LAT,
            {8'h89, 8'h00, 2'b00});
    start = 1'b1;
    dividend = 16'hFF9C;
    divisor = 8'h07;
    lat2 = 0;
    do begin
      @(posedge CLK);
      #1 lat2++;
      start = 1'b0;
    end while (!done && lat2 < 40);
    chk_res("b2b_second", lat2, LAT + 1,
            {8'hF2, 8'hFE, 2'b00});

    // reset mid-operation
    @(negedge CLK);
    start = 1'b1;
    dividend = 16'h1234;
    divisor = 8'h05;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (5) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_outs",
        {busy, done, overflow, div_by_zero,
         quotient, remainder}, 0);
    @(negedge CLK) RST = 1'b0;
    n_done = 0;
    repeat (25) begin
      @(posedge CLK);
      #1 if (done) n_done++;
    end
    chk("rst_no_done", n_done, 0);
    do_op(16'h0064, 8'h05, lat);
    chk_res("after_rst", lat, LAT,
            {8'h14, 8'h00, 2'b00});

    chk("done_busy_excl", both_hi, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
